// File: rtl/branch_predictor_gshare_spec_pkg.sv
// Shared types and sizing constants for the gshare conditional-branch predictor.
package branch_predictor_gshare_spec_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

    // Sizes of the index/history fields carried down the pipeline with each branch.
    localparam int BP_INDEX_BITS = 10;
    localparam int BP_HIST_BITS  = 10;

endpackage

// File: rtl/branch_predictor_gshare_spec_pht_ram.sv
// Pattern history table storage: one async read port, one sync write port, no reset.
// Kept as a separate module so it can be replaced by an SRAM macro.
module bp_pht_ram #(
    parameter int INDEX_BITS = 10,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  logic [CTR_BITS-1:0]   wdata,
    input  logic [INDEX_BITS-1:0] raddr,
    output logic [CTR_BITS-1:0]   rdata
);

    logic [CTR_BITS-1:0] mem [0:(1<<INDEX_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_predictor_gshare_spec.sv
// Gshare predictor: PHT indexed by PC ^ speculative global history, post-reset
// init sweep, speculative history with snapshot repair, saturating statistics.
module branch_predictor_gshare_spec
    import branch_predictor_gshare_spec_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 10,
    parameter int HIST_BITS  = 10,
    parameter int CTR_BITS   = 2,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output BranchOutcome          o_req_prediction,
    output logic [INDEX_BITS-1:0] o_req_index,
    output logic [HIST_BITS-1:0]  o_req_hist,
    output logic                  o_ready,
    input  logic                  i_fb_valid,
    input  logic [INDEX_BITS-1:0] i_fb_index,
    input  logic [HIST_BITS-1:0]  i_fb_hist,
    input  BranchOutcome          i_fb_prediction,
    input  BranchOutcome          i_fb_outcome,
    output logic [STAT_BITS-1:0]  o_branch_count,
    output logic [STAT_BITS-1:0]  o_mispredict_count
);

    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;

    bp_state_t             state_reg, state_next;
    logic [INDEX_BITS-1:0] ptr_reg;
    logic [HIST_BITS-1:0]  spec_ghr_reg;
    logic [STAT_BITS-1:0]  branch_count_reg, mispredict_count_reg;

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] req_idx;
    logic [HIST_BITS-1:0]  ghr_shift, ghr_repair;
    logic                  mispredict;
    logic                  fb_active;

    logic                  pht_we;
    logic [INDEX_BITS-1:0] pht_waddr;
    logic [CTR_BITS-1:0]   pht_wdata;
    logic [INDEX_BITS-1:0] pht_raddr [2];
    logic [CTR_BITS-1:0]   pht_rdata [2];
    logic [CTR_BITS-1:0]   fb_ctr_next;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0]};

    // Two identically-written copies give the request and feedback paths one read port each.
    assign pht_raddr[0] = req_idx;
    assign pht_raddr[1] = i_fb_index;
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pht
            bp_pht_ram #(
                .INDEX_BITS(INDEX_BITS),
                .CTR_BITS  (CTR_BITS)
            ) u_pht (
                .clk  (clk),
                .we   (pht_we),
                .waddr(pht_waddr),
                .wdata(pht_wdata),
                .raddr(pht_raddr[gi]),
                .rdata(pht_rdata[gi])
            );
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BP_INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == BP_INIT) begin
                ptr_reg <= ptr_reg + 1'b1;
            end
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (state_reg == BP_INIT && ptr_reg == '1) begin
            state_next = BP_READY;
        end
    end

    // FSM: outputs
    always_comb begin
        o_ready = (state_reg == BP_READY);
    end

    always_comb begin
        ghr_ext                = '0;
        ghr_ext[HIST_BITS-1:0] = spec_ghr_reg;
    end

    assign req_idx          = i_req_pc[INDEX_BITS+1:2] ^ ghr_ext;
    assign o_req_index      = req_idx;
    assign o_req_hist       = spec_ghr_reg;
    assign o_req_prediction = (o_ready && pht_rdata[0][CTR_BITS-1]) ? TAKEN : NOT_TAKEN;

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_shift  = o_req_prediction;
            assign ghr_repair = i_fb_outcome;
        end else begin : g_histn
            assign ghr_shift  = {spec_ghr_reg[HIST_BITS-2:0], o_req_prediction};
            assign ghr_repair = {i_fb_hist[HIST_BITS-2:0], i_fb_outcome};
        end
    endgenerate

    assign fb_active  = o_ready && i_fb_valid;
    assign mispredict = (i_fb_prediction != i_fb_outcome);

    always_comb begin
        fb_ctr_next = pht_rdata[1];
        if (i_fb_outcome == TAKEN && pht_rdata[1] != CTR_MAX) begin
            fb_ctr_next = pht_rdata[1] + 1'b1;
        end else if (i_fb_outcome == NOT_TAKEN && pht_rdata[1] != CTR_MIN) begin
            fb_ctr_next = pht_rdata[1] - 1'b1;
        end
    end

    // Single write port: sweep owns it during INIT, feedback afterwards.
    always_comb begin
        pht_we    = fb_active;
        pht_waddr = i_fb_index;
        pht_wdata = fb_ctr_next;
        if (state_reg == BP_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = ptr_reg;
            pht_wdata = CTR_WEAK_NT;
        end
    end

    // Mispredict repair takes priority over a same-cycle speculative shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_ghr_reg <= '0;
        end else if (fb_active && mispredict) begin
            spec_ghr_reg <= ghr_repair;
        end else if (o_ready && i_req_valid) begin
            spec_ghr_reg <= ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (fb_active) begin
            if (branch_count_reg != '1) begin
                branch_count_reg <= branch_count_reg + 1'b1;
            end
            if (mispredict && mispredict_count_reg != '1) begin
                mispredict_count_reg <= mispredict_count_reg + 1'b1;
            end
        end
    end

    assign o_branch_count     = branch_count_reg;
    assign o_mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor_gshare_spec.sv
// Directed bench for the gshare predictor with a 16-entry PHT, 4-bit history and 4-bit stats.
module tb_branch_predictor_gshare_spec;
    import branch_predictor_gshare_spec_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         i_req_valid;
    logic [31:0]  i_req_pc;
    BranchOutcome o_req_prediction;
    logic [3:0]   o_req_index;
    logic [3:0]   o_req_hist;
    logic         o_ready;
    logic         i_fb_valid;
    logic [3:0]   i_fb_index;
    logic [3:0]   i_fb_hist;
    BranchOutcome i_fb_prediction;
    BranchOutcome i_fb_outcome;
    logic [3:0]   o_branch_count;
    logic [3:0]   o_mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor_gshare_spec #(
        .ADDR_WIDTH(32),
        .INDEX_BITS(4),
        .HIST_BITS (4),
        .CTR_BITS  (2),
        .STAT_BITS (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_valid       (i_req_valid),
        .i_req_pc          (i_req_pc),
        .o_req_prediction  (o_req_prediction),
        .o_req_index       (o_req_index),
        .o_req_hist        (o_req_hist),
        .o_ready           (o_ready),
        .i_fb_valid        (i_fb_valid),
        .i_fb_index        (i_fb_index),
        .i_fb_hist         (i_fb_hist),
        .i_fb_prediction   (i_fb_prediction),
        .i_fb_outcome      (i_fb_outcome),
        .o_branch_count    (o_branch_count),
        .o_mispredict_count(o_mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fb(input logic [3:0] idx, input logic [3:0] hist,
                      input BranchOutcome pred, input BranchOutcome outc);
        i_fb_index      = idx;
        i_fb_hist       = hist;
        i_fb_prediction = pred;
        i_fb_outcome    = outc;
        i_fb_valid      = 1'b1;
        tick();
        i_fb_valid      = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        i_req_valid     = 1'b0;
        i_req_pc        = '0;
        i_fb_valid      = 1'b0;
        i_fb_index      = '0;
        i_fb_hist       = '0;
        i_fb_prediction = NOT_TAKEN;
        i_fb_outcome    = NOT_TAKEN;

        #12;
        chk("reset_ready", o_ready, 0);
        chk("reset_branch_cnt", o_branch_count, 0);
        chk("reset_mispred_cnt", o_mispredict_count, 0);
        chk("reset_hist", o_req_hist, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Sweep: requests and mispredicting feedback must be ignored for 16 cycles
        i_req_valid     = 1'b1;
        i_fb_valid      = 1'b1;
        i_fb_index      = 4'h2;
        i_fb_hist       = 4'hF;
        i_fb_prediction = NOT_TAKEN;
        i_fb_outcome    = TAKEN;
        for (int c = 0; c < 16; c++) begin
            i_req_pc = 32'(c) << 2;
            #1;
            chk($sformatf("init_ready_c%0d", c), o_ready, 0);
            chk($sformatf("init_pred_c%0d", c), o_req_prediction, NOT_TAKEN);
            chk($sformatf("init_hist_c%0d", c), o_req_hist, 0);
            tick();
        end
        i_req_valid = 1'b0;
        i_fb_valid  = 1'b0;
        #1;
        chk("ready_after_sweep", o_ready, 1);
        chk("init_branch_cnt", o_branch_count, 0);
        chk("init_mispred_cnt", o_mispredict_count, 0);
        chk("init_hist_held", o_req_hist, 0);
        tick();

        for (int i = 0; i < 16; i++) begin
            i_req_pc = 32'(i) << 2;
            #1;
            chk($sformatf("swept_idx_%0d", i), o_req_index, i);
            chk($sformatf("swept_pred_%0d", i), o_req_prediction, NOT_TAKEN);
            tick();
        end

        // Hashing and training of index 2
        i_req_pc = 32'h0040_0008;
        #1;
        chk("hash_idx", o_req_index, 4'h2);
        chk("hash_pred_initial", o_req_prediction, NOT_TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        #1;
        chk("train_two_taken", o_req_prediction, TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        fb(4'h2, 4'h0, NOT_TAKEN, NOT_TAKEN);
        #1;
        chk("sat_hi_then_nt", o_req_prediction, TAKEN);
        chk("train_branch_cnt", o_branch_count, 4);

        // Request reads the old counter while feedback writes the same entry
        i_fb_index      = 4'h2;
        i_fb_hist       = 4'h0;
        i_fb_prediction = NOT_TAKEN;
        i_fb_outcome    = NOT_TAKEN;
        i_fb_valid      = 1'b1;
        #1;
        chk("rbw_old_value", o_req_prediction, TAKEN);
        tick();
        i_fb_valid = 1'b0;
        #1;
        chk("rbw_new_value", o_req_prediction, NOT_TAKEN);

        fb(4'h2, 4'h0, NOT_TAKEN, NOT_TAKEN);
        fb(4'h2, 4'h0, NOT_TAKEN, NOT_TAKEN);
        #1;
        chk("sat_lo_pred", o_req_prediction, NOT_TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        #1;
        chk("sat_lo_then_taken", o_req_prediction, NOT_TAKEN);
        chk("train_branch_cnt2", o_branch_count, 8);
        chk("train_mispred_cnt", o_mispredict_count, 0);

        // Speculative history: T, N, T
        fb(4'h5, 4'h0, TAKEN, TAKEN);
        fb(4'h5, 4'h0, TAKEN, TAKEN);
        i_req_valid = 1'b1;
        i_req_pc    = 32'h14;
        #1;
        chk("spec1_idx", o_req_index, 4'h5);
        chk("spec1_pred", o_req_prediction, TAKEN);
        chk("spec1_hist", o_req_hist, 4'h0);
        tick();
        i_req_pc = 32'h0;
        #1;
        chk("spec2_idx", o_req_index, 4'h1);
        chk("spec2_pred", o_req_prediction, NOT_TAKEN);
        chk("spec2_hist", o_req_hist, 4'h1);
        tick();
        i_req_pc = 32'h1C;
        #1;
        chk("spec3_idx", o_req_index, 4'h5);
        chk("spec3_pred", o_req_prediction, TAKEN);
        chk("spec3_hist", o_req_hist, 4'h2);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("spec_final_hist", o_req_hist, 4'h5);

        // Repair overrides a same-cycle request shift
        i_req_valid     = 1'b1;
        i_req_pc        = 32'h0;
        i_fb_index      = 4'h9;
        i_fb_hist       = 4'h3;
        i_fb_prediction = NOT_TAKEN;
        i_fb_outcome    = TAKEN;
        i_fb_valid      = 1'b1;
        #1;
        chk("repair_req_pred", o_req_prediction, TAKEN);
        tick();
        i_req_valid = 1'b0;
        i_fb_valid  = 1'b0;
        #1;
        chk("repair_hist", o_req_hist, 4'h7);
        chk("repair_mispred_cnt", o_mispredict_count, 1);
        chk("repair_branch_cnt", o_branch_count, 11);

        // Statistics saturation
        for (int k = 0; k < 20; k++) begin
            fb(4'h0, 4'h0, TAKEN, NOT_TAKEN);
            if (k == 3) begin
                #1;
                chk("stat_mid_branch", o_branch_count, 15);
                chk("stat_mid_mispred", o_mispredict_count, 5);
            end
        end
        #1;
        chk("stat_sat_branch", o_branch_count, 4'hF);
        chk("stat_sat_mispred", o_mispredict_count, 4'hF);
        chk("stat_hist", o_req_hist, 4'h0);

        // Asynchronous reset mid-operation
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        fb(4'h2, 4'h0, TAKEN, TAKEN);
        i_req_valid = 1'b1;
        i_req_pc    = 32'h8;
        #1;
        chk("pre_rst_idx", o_req_index, 4'h2);
        chk("pre_rst_pred", o_req_prediction, TAKEN);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("pre_rst_hist", o_req_hist, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", o_ready, 0);
        chk("async_rst_hist", o_req_hist, 0);
        chk("async_rst_branch", o_branch_count, 0);
        chk("async_rst_mispred", o_mispredict_count, 0);
        chk("async_rst_pred", o_req_prediction, NOT_TAKEN);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk($sformatf("resweep_ready_c%0d", c), o_ready, 0);
            tick();
        end
        #1;
        chk("resweep_ready", o_ready, 1);
        chk("resweep_idx", o_req_index, 4'h2);
        chk("resweep_pred", o_req_prediction, NOT_TAKEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
